data_addr_trans_stage: RTL and testbench
========================================

Name: data_addr_trans_stage

Overview:
- LSU address-translation stage. Sits directly upstream of the MMU data port and consumes its one-cycle-later response.
- S0 accepts a load/store from the issue queue and drives the MMU data translation request.
- S1 captures the MMU response, checks data-access exceptions, and hands paddr/uncache/exception info downstream to the DCache request stage over a valid/ready handshake.

Parameters:
- ROB_IDX_W, 6, width of the reorder-buffer tag carried with each request
- PALEN, 32, physical address width

Ports:
- clk  in  1  clock
- a_rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; kills S1 and any S0 acceptance
- req_valid_i  in  1  LSU request valid
- req_ready_o  out  1  stage can accept
- req_vaddr_i  in  32  virtual address
- req_store_i  in  1  1=store, 0=load
- req_size_i  in  2  0=B, 1=H, 2=W
- req_rob_idx_i  in  ROB_IDX_W  tag
- csr_plv_i  in  2  current privilege level
- csr_da_i  in  1  CRMD.DA
- csr_pg_i  in  1  CRMD.PG
- csr_dmw0_i  in  32  DMW0
- csr_dmw1_i  in  32  DMW1
- mmu_req_valid_o  out  1  to MMU data_trans_req.valid
- mmu_req_vaddr_o  out  32  to MMU data_trans_req.vaddr
- mmu_rsp_paddr_i  in  PALEN  MMU paddr (for vaddr sent last cycle)
- mmu_rsp_uncache_i  in  1  MMU uncache
- mmu_rsp_miss_i  in  1  TLB miss
- mmu_rsp_tlb_valid_i  in  1  entry V bit
- mmu_rsp_tlb_dirty_i  in  1  entry D bit
- mmu_rsp_tlb_plv_i  in  2  entry PLV
- out_valid_o  out  1  S1 valid
- out_ready_i  in  1  downstream ready
- out_paddr_o  out  PALEN  physical address
- out_uncache_o  out  1  uncached access
- out_store_o  out  1  store flag
- out_size_o  out  2  access size
- out_rob_idx_o  out  ROB_IDX_W  tag
- out_exc_o  out  1  exception present
- out_ecode_o  out  6  exception code
- out_badv_o  out  32  faulting vaddr

Behaviour:
- Reset: s1_valid=0, all S1 payload regs=0; out_valid_o=0, out_exc_o=0, out_ecode_o=0, out_badv_o=0, out_paddr_o=0.
- s1_fire = s1_valid && out_ready_i. req_ready_o = (!s1_valid || out_ready_i) && !flush_i. s0_fire = req_valid_i && req_ready_o.
- MMU has fixed 1-cycle latency and re-registers vaddr every cycle. Therefore:
  - mmu_req_vaddr_o = s0_fire ? req_vaddr_i : s1_vaddr (replay keeps the response stable while S1 stalls).
  - mmu_req_valid_o = s0_fire || s1_valid.
- S1 update on clk edge:
  - flush_i: s1_valid<=0, regardless of fires.
  - else s0_fire: load payload, s1_valid<=1.
  - else s1_fire: s1_valid<=0.
  - else hold.
  - Simultaneous s1_fire and s0_fire: back-to-back throughput of 1/cycle.
- Outputs are combinational from S1 regs plus MMU rsp; payload (paddr, uncache, exc) remains valid for every stalled cycle.
- tlb_mapped = csr_pg_i && !csr_da_i && !dmw_hit(s1_vaddr), where dmw_hit follows the DMW PLV0/PLV3 enable bits and VSEG[31:29] match.
- Exception priority, evaluated in S1, first match wins:
  - ALE 0x09: misaligned (size H && vaddr[0]; size W && vaddr[1:0]!=0).
  - TLBR 0x3F: tlb_mapped && miss.
  - PIL 0x01 (load) / PIS 0x02 (store): tlb_mapped && !tlb_valid.
  - PPI 0x07: tlb_mapped && csr_plv_i > tlb_plv.
  - PME 0x04: tlb_mapped && store && !tlb_dirty.
  - No exception: out_ecode_o=0, out_exc_o=0.
  - out_badv_o = s1_vaddr whenever out_exc_o, else 0.
- MMU miss/valid/dirty/plv are ignored when !tlb_mapped.
- Reset mid-operation drops S1 immediately (asynchronous). Flush during a stall discards the held request; the next cycle accepts new input.

Optional Feature:
- Macro DATA_TRANS_PERF_CNT_EN.
- Defined: adds 32-bit saturating counters perf_tlb_miss_o (increments on s1_fire with TLBR) and perf_stall_o (increments each cycle s1_valid && !out_ready_i). Both reset to 0 and hold at 0xFFFF_FFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (MemoryManagementUnit.svh): ecode constants (ECODE_ALE/TLBR/PIL/PIS/PPI/PME), a DataTransS1St payload struct, and DMW field macros (reuse existing PLV0/PLV3/VSEG).
- One sub-module, data_exc_check: pure combinational priority encoder computing exc/ecode from the S1 payload, MMU rsp, and tlb_mapped.

Test Plan:
- DA mode (da=1, pg=0), load W at 0x1000_0004, out_ready=1 -> out_valid next cycle, paddr=mmu_rsp_paddr, exc=0; back-to-back loads accept every cycle.
- PG mode, dmw0=0x8000_0001 (VSEG=4, PLV0), plv=0, vaddr 0x8000_0010 with miss=1 -> no exception (DMW bypass).
- PG mode, no DMW hit, miss=1, store -> exc=1, ecode=0x3F, badv=vaddr. Same with miss=0, valid=1, dirty=0 -> ecode=0x04.
- Load H at 0x...01 with miss=1 -> ecode=0x09 (ALE beats TLBR). plv=3, tlb_plv=0, valid=1 -> ecode=0x07.
- Hold out_ready=0 for 3 cycles -> mmu_req_vaddr_o=s1_vaddr each cycle, outputs stable, req_ready=0. Release -> new request accepted the same cycle.
- flush_i asserted during stall -> out_valid=0 next cycle, held request never issued. With DATA_TRANS_PERF_CNT_EN, perf_stall_o counts 3.

Source files
------------

// File: rtl/data_addr_trans_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_addr_trans_stage_pkg
// Description : Shared definitions for the LSU data address-translation
//               stage: data-access exception codes, access-size encodings,
//               DMW register field positions, the S1 payload struct and a
//               direct-mapped-window hit helper.
// Revision    : 1.0 - initial release
// ============================================================================
package data_addr_trans_stage_pkg;

    // Exception codes reported on out_ecode_o
    localparam logic [5:0] c_ecode_none = 6'h00;
    localparam logic [5:0] c_ecode_pil  = 6'h01;
    localparam logic [5:0] c_ecode_pis  = 6'h02;
    localparam logic [5:0] c_ecode_pme  = 6'h04;
    localparam logic [5:0] c_ecode_ppi  = 6'h07;
    localparam logic [5:0] c_ecode_ale  = 6'h09;
    localparam logic [5:0] c_ecode_tlbr = 6'h3F;

    // Access size encodings
    localparam logic [1:0] c_size_b = 2'd0;
    localparam logic [1:0] c_size_h = 2'd1;
    localparam logic [1:0] c_size_w = 2'd2;

    // DMW register fields
    localparam int c_dmw_plv0_bit = 0;
    localparam int c_dmw_plv3_bit = 3;
    localparam int c_dmw_vseg_msb = 31;
    localparam int c_dmw_vseg_lsb = 29;

    // Payload captured into S1 on acceptance
    typedef struct packed {
        logic [31:0] vaddr;
        logic        store;
        logic [1:0]  size;
    } data_trans_s1_t;

    // A window hits when it is enabled for the current privilege level
    // (only PLV0 and PLV3 have enable bits) and the top three vaddr bits
    // match its VSEG field.
    function automatic logic dmw_hit(
        input logic       plv0_en,
        input logic       plv3_en,
        input logic [2:0] vseg,
        input logic [1:0] plv,
        input logic [2:0] vaddr_seg
    );
        logic plv_ok;
        plv_ok = ((plv == 2'd0) && plv0_en) || ((plv == 2'd3) && plv3_en);
        return plv_ok && (vseg == vaddr_seg);
    endfunction

endpackage : data_addr_trans_stage_pkg
`default_nettype wire

// File: rtl/data_exc_check.sv
`default_nettype none
// ============================================================================
// Module      : data_exc_check
// Description : Combinational priority encoder for data-access exceptions
//               of the request held in S1.
//               Priority: ALE > TLBR > PIL/PIS > PPI > PME.
// Ports       : vaddr_lo   - low two bits of the S1 virtual address
//               store      - 1 = store, 0 = load
//               size       - access size (0=B, 1=H, 2=W)
//               tlb_mapped - address is translated through the TLB
//               csr_plv    - current privilege level
//               tlb_miss/tlb_valid/tlb_dirty/tlb_plv - MMU response fields
//               exc        - exception present
//               ecode      - exception code (0 when no exception)
// Revision    : 1.0 - initial release
// ============================================================================
module data_exc_check
    import data_addr_trans_stage_pkg::*;
(
    input  logic [1:0] vaddr_lo,
    input  logic       store,
    input  logic [1:0] size,
    input  logic       tlb_mapped,
    input  logic [1:0] csr_plv,
    input  logic       tlb_miss,
    input  logic       tlb_valid,
    input  logic       tlb_dirty,
    input  logic [1:0] tlb_plv,
    output logic       exc,
    output logic [5:0] ecode
);

    logic w_misaligned;

    // Byte accesses are never misaligned; size 3 is unused and never faults.
    assign w_misaligned = ((size == c_size_h) && vaddr_lo[0]) ||
                          ((size == c_size_w) && (vaddr_lo != 2'b00));

    always_comb begin
        ecode = c_ecode_none;
        if (w_misaligned) begin
            ecode = c_ecode_ale;
        end else if (tlb_mapped && tlb_miss) begin
            ecode = c_ecode_tlbr;
        end else if (tlb_mapped && !tlb_valid) begin
            ecode = store ? c_ecode_pis : c_ecode_pil;
        end else if (tlb_mapped && (csr_plv > tlb_plv)) begin
            ecode = c_ecode_ppi;
        end else if (tlb_mapped && store && !tlb_dirty) begin
            ecode = c_ecode_pme;
        end
    end

    assign exc = (ecode != c_ecode_none);

endmodule : data_exc_check
`default_nettype wire

// File: rtl/data_addr_trans_stage.sv
`default_nettype none
// ============================================================================
// Module      : data_addr_trans_stage
// Description : LSU address-translation stage.
//               S0 accepts a load/store and issues the MMU data translation
//               request. S1 holds the request while the MMU answers one
//               cycle later, checks data-access exceptions and presents
//               paddr/uncache/exception info downstream over valid/ready.
// Ports       : clk, a_rst_n (async active-low), flush_i
//               req_*      - request from the issue queue (valid/ready)
//               csr_*      - PLV, CRMD.DA/PG, DMW0/DMW1
//               mmu_req_*  - translation request to the MMU
//               mmu_rsp_*  - MMU response for the vaddr sent last cycle
//               out_*      - S1 result to the DCache request stage
// Config      : DATA_TRANS_PERF_CNT_EN adds saturating counters
//               perf_tlb_miss_o and perf_stall_o.
// Revision    : 1.0 - initial release
// ============================================================================
module data_addr_trans_stage
    import data_addr_trans_stage_pkg::*;
#(
    parameter int ROB_IDX_W = 6,
    parameter int PALEN     = 32
) (
    input  logic                 clk,
    input  logic                 a_rst_n,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [31:0]          req_vaddr_i,
    input  logic                 req_store_i,
    input  logic [1:0]           req_size_i,
    input  logic [ROB_IDX_W-1:0] req_rob_idx_i,
    input  logic [1:0]           csr_plv_i,
    input  logic                 csr_da_i,
    input  logic                 csr_pg_i,
    input  logic [31:0]          csr_dmw0_i,
    input  logic [31:0]          csr_dmw1_i,
    output logic                 mmu_req_valid_o,
    output logic [31:0]          mmu_req_vaddr_o,
    input  logic [PALEN-1:0]     mmu_rsp_paddr_i,
    input  logic                 mmu_rsp_uncache_i,
    input  logic                 mmu_rsp_miss_i,
    input  logic                 mmu_rsp_tlb_valid_i,
    input  logic                 mmu_rsp_tlb_dirty_i,
    input  logic [1:0]           mmu_rsp_tlb_plv_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PALEN-1:0]     out_paddr_o,
    output logic                 out_uncache_o,
    output logic                 out_store_o,
    output logic [1:0]           out_size_o,
    output logic [ROB_IDX_W-1:0] out_rob_idx_o,
    output logic                 out_exc_o,
    output logic [5:0]           out_ecode_o,
    output logic [31:0]          out_badv_o
`ifdef DATA_TRANS_PERF_CNT_EN
    ,
    output logic [31:0]          perf_tlb_miss_o,
    output logic [31:0]          perf_stall_o
`endif
);

    logic                 r_s1_valid;
    data_trans_s1_t       r_s1;
    logic [ROB_IDX_W-1:0] r_s1_rob_idx;

    logic       w_s0_fire;
    logic       w_s1_fire;
    logic       w_dmw0_hit;
    logic       w_dmw1_hit;
    logic       w_tlb_mapped;
    logic       w_exc;
    logic [5:0] w_ecode;
    logic       w_unused_dmw_bits;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign w_s1_fire   = r_s1_valid && out_ready_i;
    assign req_ready_o = (!r_s1_valid || out_ready_i) && !flush_i;
    assign w_s0_fire   = req_valid_i && req_ready_o;

    // The MMU re-registers its input every cycle, so while S1 stalls the
    // held vaddr is replayed to keep the response stable.
    assign mmu_req_vaddr_o = w_s0_fire ? req_vaddr_i : r_s1.vaddr;
    assign mmu_req_valid_o = w_s0_fire || r_s1_valid;

    // ------------------------------------------------------------------
    // S1 register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1         <= '0;
            r_s1_rob_idx <= '0;
        end else if (flush_i) begin
            r_s1_valid <= 1'b0;
        end else if (w_s0_fire) begin
            r_s1_valid       <= 1'b1;
            r_s1.vaddr       <= req_vaddr_i;
            r_s1.store       <= req_store_i;
            r_s1.size        <= req_size_i;
            r_s1_rob_idx     <= req_rob_idx_i;
        end else if (w_s1_fire) begin
            r_s1_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Translation mode and exception check
    // ------------------------------------------------------------------
    assign w_dmw0_hit = dmw_hit(csr_dmw0_i[c_dmw_plv0_bit], csr_dmw0_i[c_dmw_plv3_bit],
                                csr_dmw0_i[c_dmw_vseg_msb:c_dmw_vseg_lsb], csr_plv_i,
                                r_s1.vaddr[c_dmw_vseg_msb:c_dmw_vseg_lsb]);
    assign w_dmw1_hit = dmw_hit(csr_dmw1_i[c_dmw_plv0_bit], csr_dmw1_i[c_dmw_plv3_bit],
                                csr_dmw1_i[c_dmw_vseg_msb:c_dmw_vseg_lsb], csr_plv_i,
                                r_s1.vaddr[c_dmw_vseg_msb:c_dmw_vseg_lsb]);

    assign w_tlb_mapped = csr_pg_i && !csr_da_i && !(w_dmw0_hit || w_dmw1_hit);

    // MAT and reserved DMW fields do not affect this stage.
    assign w_unused_dmw_bits = ^{csr_dmw0_i[28:4], csr_dmw0_i[2:1],
                                 csr_dmw1_i[28:4], csr_dmw1_i[2:1]};

    data_exc_check u_exc_check (
        .vaddr_lo   (r_s1.vaddr[1:0]),
        .store      (r_s1.store),
        .size       (r_s1.size),
        .tlb_mapped (w_tlb_mapped),
        .csr_plv    (csr_plv_i),
        .tlb_miss   (mmu_rsp_miss_i),
        .tlb_valid  (mmu_rsp_tlb_valid_i),
        .tlb_dirty  (mmu_rsp_tlb_dirty_i),
        .tlb_plv    (mmu_rsp_tlb_plv_i),
        .exc        (w_exc),
        .ecode      (w_ecode)
    );

    // ------------------------------------------------------------------
    // Outputs: MMU-derived fields are masked to zero while S1 is empty so
    // the stage presents a clean idle state.
    // ------------------------------------------------------------------
    assign out_valid_o   = r_s1_valid;
    assign out_paddr_o   = r_s1_valid ? mmu_rsp_paddr_i : '0;
    assign out_uncache_o = r_s1_valid && mmu_rsp_uncache_i;
    assign out_store_o   = r_s1.store;
    assign out_size_o    = r_s1.size;
    assign out_rob_idx_o = r_s1_rob_idx;
    assign out_exc_o     = r_s1_valid && w_exc;
    assign out_ecode_o   = out_exc_o ? w_ecode : c_ecode_none;
    assign out_badv_o    = out_exc_o ? r_s1.vaddr : 32'h0;

`ifdef DATA_TRANS_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [31:0] r_perf_tlb_miss;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_perf_tlb_miss <= 32'h0;
            r_perf_stall    <= 32'h0;
        end else begin
            if (w_s1_fire && out_exc_o && (out_ecode_o == c_ecode_tlbr) &&
                (r_perf_tlb_miss != 32'hFFFF_FFFF)) begin
                r_perf_tlb_miss <= r_perf_tlb_miss + 32'd1;
            end
            if (r_s1_valid && !out_ready_i && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_tlb_miss_o = r_perf_tlb_miss;
    assign perf_stall_o    = r_perf_stall;
`endif

endmodule : data_addr_trans_stage
`default_nettype wire

// File: tb/tb_data_addr_trans_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_addr_trans_stage
// Description : Self-checking bench for data_addr_trans_stage. A small MMU
//               model answers one cycle after each request; expected results
//               are queued when a request is driven and compared when the
//               stage hands it downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_addr_trans_stage;

    localparam int ROB_IDX_W = 6;
    localparam int PALEN     = 32;

    logic                 clk = 1'b0;
    logic                 a_rst_n;
    logic                 flush_i;
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [31:0]          req_vaddr_i;
    logic                 req_store_i;
    logic [1:0]           req_size_i;
    logic [ROB_IDX_W-1:0] req_rob_idx_i;
    logic [1:0]           csr_plv_i;
    logic                 csr_da_i;
    logic                 csr_pg_i;
    logic [31:0]          csr_dmw0_i;
    logic [31:0]          csr_dmw1_i;
    logic                 mmu_req_valid_o;
    logic [31:0]          mmu_req_vaddr_o;
    logic [PALEN-1:0]     mmu_rsp_paddr_i;
    logic                 mmu_rsp_uncache_i;
    logic                 mmu_rsp_miss_i;
    logic                 mmu_rsp_tlb_valid_i;
    logic                 mmu_rsp_tlb_dirty_i;
    logic [1:0]           mmu_rsp_tlb_plv_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [PALEN-1:0]     out_paddr_o;
    logic                 out_uncache_o;
    logic                 out_store_o;
    logic [1:0]           out_size_o;
    logic [ROB_IDX_W-1:0] out_rob_idx_o;
    logic                 out_exc_o;
    logic [5:0]           out_ecode_o;
    logic [31:0]          out_badv_o;
`ifdef DATA_TRANS_PERF_CNT_EN
    logic [31:0]          perf_tlb_miss_o;
    logic [31:0]          perf_stall_o;
`endif

    always #5 clk = ~clk;

    data_addr_trans_stage #(
        .ROB_IDX_W (ROB_IDX_W),
        .PALEN     (PALEN)
    ) dut (
        .clk                 (clk),
        .a_rst_n             (a_rst_n),
        .flush_i             (flush_i),
        .req_valid_i         (req_valid_i),
        .req_ready_o         (req_ready_o),
        .req_vaddr_i         (req_vaddr_i),
        .req_store_i         (req_store_i),
        .req_size_i          (req_size_i),
        .req_rob_idx_i       (req_rob_idx_i),
        .csr_plv_i           (csr_plv_i),
        .csr_da_i            (csr_da_i),
        .csr_pg_i            (csr_pg_i),
        .csr_dmw0_i          (csr_dmw0_i),
        .csr_dmw1_i          (csr_dmw1_i),
        .mmu_req_valid_o     (mmu_req_valid_o),
        .mmu_req_vaddr_o     (mmu_req_vaddr_o),
        .mmu_rsp_paddr_i     (mmu_rsp_paddr_i),
        .mmu_rsp_uncache_i   (mmu_rsp_uncache_i),
        .mmu_rsp_miss_i      (mmu_rsp_miss_i),
        .mmu_rsp_tlb_valid_i (mmu_rsp_tlb_valid_i),
        .mmu_rsp_tlb_dirty_i (mmu_rsp_tlb_dirty_i),
        .mmu_rsp_tlb_plv_i   (mmu_rsp_tlb_plv_i),
        .out_valid_o         (out_valid_o),
        .out_ready_i         (out_ready_i),
        .out_paddr_o         (out_paddr_o),
        .out_uncache_o       (out_uncache_o),
        .out_store_o         (out_store_o),
        .out_size_o          (out_size_o),
        .out_rob_idx_o       (out_rob_idx_o),
        .out_exc_o           (out_exc_o),
        .out_ecode_o         (out_ecode_o),
        .out_badv_o          (out_badv_o)
`ifdef DATA_TRANS_PERF_CNT_EN
        ,
        .perf_tlb_miss_o     (perf_tlb_miss_o),
        .perf_stall_o        (perf_stall_o)
`endif
    );

    // ------------------------------------------------------------------
    // MMU model: fixed one-cycle latency, simple address scramble
    // ------------------------------------------------------------------
    function automatic logic [31:0] mmu_xform(input logic [31:0] v);
        return v ^ 32'h5A00_0000;
    endfunction

    always @(posedge clk) begin
        mmu_rsp_paddr_i   <= mmu_xform(mmu_req_vaddr_o);
        mmu_rsp_uncache_i <= mmu_req_vaddr_o[31];
    end

    // ------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] paddr;
        logic        uncache;
        logic        exc;
        logic [5:0]  ecode;
        logic [31:0] badv;
        logic        store;
        logic [1:0]  size;
        logic [5:0]  rob;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Compare every downstream handoff against the oldest expectation.
    always @(negedge clk) begin
        if (a_rst_n && out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: rob=%0d handed off, none expected", out_rob_idx_o);
            end else begin
                mon_e = sb.pop_front();
                check("out_paddr",   64'(out_paddr_o),   64'(mon_e.paddr));
                check("out_uncache", 64'(out_uncache_o), 64'(mon_e.uncache));
                check("out_exc",     64'(out_exc_o),     64'(mon_e.exc));
                check("out_ecode",   64'(out_ecode_o),   64'(mon_e.ecode));
                check("out_badv",    64'(out_badv_o),    64'(mon_e.badv));
                check("out_store_size_rob",
                      64'({out_store_o, out_size_o, out_rob_idx_o}),
                      64'({mon_e.store, mon_e.size, mon_e.rob}));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] va, input logic st, input logic [1:0] sz,
                         input logic [5:0] rob, input logic [5:0] ecode, input logic push);
        exp_t e;
        req_valid_i   = 1'b1;
        req_vaddr_i   = va;
        req_store_i   = st;
        req_size_i    = sz;
        req_rob_idx_i = rob;
        if (push) begin
            e.paddr   = mmu_xform(va);
            e.uncache = va[31];
            e.exc     = (ecode != 6'h00);
            e.ecode   = ecode;
            e.badv    = (ecode != 6'h00) ? va : 32'h0;
            e.store   = st;
            e.size    = sz;
            e.rob     = rob;
            sb.push_back(e);
        end
    endtask

    task automatic set_da_mode();
        csr_da_i = 1'b1; csr_pg_i = 1'b0; csr_plv_i = 2'd0;
        csr_dmw0_i = 32'h0; csr_dmw1_i = 32'h0;
        mmu_rsp_miss_i = 1'b0; mmu_rsp_tlb_valid_i = 1'b1;
        mmu_rsp_tlb_dirty_i = 1'b1; mmu_rsp_tlb_plv_i = 2'd3;
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] vaddr;
        logic        store;
        logic [1:0]  size;
        logic        da;
        logic        pg;
        logic [31:0] dmw0;
        logic [31:0] dmw1;
        logic [1:0]  plv;
        logic        miss;
        logic        tv;
        logic        td;
        logic [1:0]  tplv;
        logic [5:0]  ecode;
    } vec_t;

    localparam int NVEC = 13;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic [31:0] va, input logic st, input logic [1:0] sz,
                                input logic da, input logic pg, input logic [31:0] d0,
                                input logic [31:0] d1, input logic [1:0] plv, input logic miss,
                                input logic tv, input logic td, input logic [1:0] tplv,
                                input logic [5:0] ec);
        vec_t v;
        v.vaddr = va; v.store = st; v.size = sz; v.da = da; v.pg = pg;
        v.dmw0 = d0; v.dmw1 = d1; v.plv = plv; v.miss = miss; v.tv = tv;
        v.td = td; v.tplv = tplv; v.ecode = ec;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            vaddr        st  sz  da  pg  dmw0          dmw1          plv miss tv td tplv ecode
        tbl[0]  = mk(32'h1000_0004, 0, 2, 1, 0, 32'h0,        32'h0,        0, 1, 0, 0, 0, 6'h00); // DA: ignores TLB
        tbl[1]  = mk(32'h8000_0010, 0, 2, 0, 1, 32'h8000_0001, 32'h0,       0, 1, 0, 0, 0, 6'h00); // DMW0 PLV0 bypass
        tbl[2]  = mk(32'h0000_1000, 1, 2, 0, 1, 32'h0,        32'h0,        0, 1, 1, 1, 0, 6'h3F); // TLBR
        tbl[3]  = mk(32'h0000_2000, 1, 2, 0, 1, 32'h0,        32'h0,        0, 0, 1, 0, 0, 6'h04); // PME
        tbl[4]  = mk(32'h0000_3001, 0, 1, 0, 1, 32'h0,        32'h0,        0, 1, 1, 1, 0, 6'h09); // ALE beats TLBR
        tbl[5]  = mk(32'h0000_4000, 0, 2, 0, 1, 32'h0,        32'h0,        3, 0, 1, 1, 0, 6'h07); // PPI
        tbl[6]  = mk(32'h0000_5003, 0, 0, 0, 1, 32'h0,        32'h0,        0, 0, 0, 1, 0, 6'h01); // PIL
        tbl[7]  = mk(32'h0000_5007, 1, 0, 0, 1, 32'h0,        32'h0,        0, 0, 0, 1, 0, 6'h02); // PIS
        tbl[8]  = mk(32'h8000_0010, 0, 2, 0, 1, 32'h8000_0001, 32'h0,       3, 1, 1, 1, 0, 6'h3F); // DMW0 not for PLV3
        tbl[9]  = mk(32'h9000_0000, 0, 2, 0, 1, 32'h0,        32'h8000_0008, 3, 1, 0, 0, 0, 6'h00); // DMW1 PLV3 bypass
        tbl[10] = mk(32'h0000_6000, 1, 2, 0, 1, 32'h0,        32'h0,        3, 0, 1, 1, 3, 6'h00); // mapped, all ok
        tbl[11] = mk(32'h1000_0002, 0, 2, 1, 0, 32'h0,        32'h0,        0, 0, 1, 1, 0, 6'h09); // ALE in DA mode
        tbl[12] = mk(32'h0000_7002, 0, 1, 0, 1, 32'h0,        32'h0,        0, 0, 1, 0, 0, 6'h00); // aligned H load

        // ---------------- reset state ----------------
        a_rst_n = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_vaddr_i = 32'h0;
        req_store_i = 1'b0; req_size_i = 2'd0; req_rob_idx_i = '0; out_ready_i = 1'b1;
        set_da_mode();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid_o), 64'h0);
        check("rst_out_exc",   64'(out_exc_o),   64'h0);
        check("rst_out_ecode", 64'(out_ecode_o), 64'h0);
        check("rst_out_badv",  64'(out_badv_o),  64'h0);
        check("rst_out_paddr", 64'(out_paddr_o), 64'h0);
        check("rst_mmu_valid", 64'(mmu_req_valid_o), 64'h0);
`ifdef DATA_TRANS_PERF_CNT_EN
        check("rst_perf_stall", 64'(perf_stall_o), 64'h0);
`endif
        step();
        a_rst_n = 1'b1;

        // ---------------- table vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            step();
            csr_da_i = tbl[i].da; csr_pg_i = tbl[i].pg; csr_plv_i = tbl[i].plv;
            csr_dmw0_i = tbl[i].dmw0; csr_dmw1_i = tbl[i].dmw1;
            mmu_rsp_miss_i = tbl[i].miss; mmu_rsp_tlb_valid_i = tbl[i].tv;
            mmu_rsp_tlb_dirty_i = tbl[i].td; mmu_rsp_tlb_plv_i = tbl[i].tplv;
            issue(tbl[i].vaddr, tbl[i].store, tbl[i].size, 6'(i), tbl[i].ecode, 1'b1);
            @(negedge clk);
            check("tbl_req_ready", 64'(req_ready_o), 64'h1);
            check("tbl_mmu_vaddr", 64'(mmu_req_vaddr_o), 64'(tbl[i].vaddr));
            step();
            req_valid_i = 1'b0;
            step();
        end

        // ---------------- back-to-back loads ----------------
        set_da_mode();
        step();
        for (int k = 0; k < 5; k++) begin
            issue(32'h1000_0000 + 32'(k * 4), 1'b0, 2'd2, 6'(20 + k), 6'h00, 1'b1);
            @(negedge clk);
            check("b2b_req_ready", 64'(req_ready_o), 64'h1);
            step();
        end
        req_valid_i = 1'b0;
        step();
        step();
        check("b2b_drained", 64'(sb.size()), 64'h0);

        // ---------------- 3-cycle stall, release accepts same cycle ----------------
        out_ready_i = 1'b0;
        issue(32'h1000_0100, 1'b0, 2'd2, 6'd40, 6'h00, 1'b1);
        step();
        issue(32'h1000_0200, 1'b1, 2'd2, 6'd41, 6'h00, 1'b1);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("stall_req_ready", 64'(req_ready_o), 64'h0);
            check("stall_mmu_vaddr", 64'(mmu_req_vaddr_o), 64'h1000_0100);
            check("stall_out_valid", 64'(out_valid_o), 64'h1);
            check("stall_out_paddr", 64'(out_paddr_o), 64'(mmu_xform(32'h1000_0100)));
            step();
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        check("release_req_ready", 64'(req_ready_o), 64'h1);
        check("release_mmu_vaddr", 64'(mmu_req_vaddr_o), 64'h1000_0200);
        step();
        req_valid_i = 1'b0;
        step();
`ifdef DATA_TRANS_PERF_CNT_EN
        check("perf_stall", 64'(perf_stall_o), 64'd3);
`endif
        check("stall_drained", 64'(sb.size()), 64'h0);

        // ---------------- flush during stall ----------------
        out_ready_i = 1'b0;
        issue(32'h1000_0300, 1'b0, 2'd2, 6'd50, 6'h00, 1'b0);
        step();
        req_valid_i = 1'b0;
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_req_ready", 64'(req_ready_o), 64'h0);
        step();
        flush_i = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid_o), 64'h0);
        check("flush_req_ready_after", 64'(req_ready_o), 64'h1);
        out_ready_i = 1'b1;
        step();
        issue(32'h1000_0400, 1'b0, 2'd2, 6'd51, 6'h00, 1'b1);
        step();
        req_valid_i = 1'b0;
        step();
        step();

        // ---------------- asynchronous reset mid-operation ----------------
        out_ready_i = 1'b0;
        issue(32'h1000_0500, 1'b0, 2'd2, 6'd60, 6'h00, 1'b0);
        step();
        req_valid_i = 1'b0;
        #2;
        a_rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid_o), 64'h0);
        check("async_rst_paddr", 64'(out_paddr_o), 64'h0);
        step();
        a_rst_n = 1'b1;
        out_ready_i = 1'b1;
        step();
        issue(32'h1000_0600, 1'b1, 2'd1, 6'd61, 6'h00, 1'b1);
        step();
        req_valid_i = 1'b0;
        step();
        step();
        check("final_sb_empty", 64'(sb.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_data_addr_trans_stage
`default_nettype wire
